clk_div_prog: RTL

//  Parametrised, runtime-programmable integer clock divider; successor to the fixed

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_shadow.sv | 59 +++++
 rtl/clk_div_prog.sv | 92 +++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and divisor helpers for the programmable clock divider
// Contents:
//   MIN_DIV    smallest divisor the hardware will run with
//   clamp_div  raises any requested divisor below MIN_DIV up to MIN_DIV
//   half_div   number of high cycles in one period, ceil(D/2)
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned clamp_div(input int unsigned v);
        return (v < MIN_DIV) ? MIN_DIV : v;
    endfunction

    function automatic int unsigned half_div(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// rtl/clk_div_shadow.sv - divisor shadow register with apply-at-period-boundary
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   div_in_i        requested divisor
//   div_load_i      one-cycle strobe capturing div_in_i into the shadow
//   apply_i         high on the enabled edge that starts a new period
//   div_cur_o       divisor currently in effect
//   div_pending_o   shadow holds a divisor not yet applied
module clk_div_shadow
    import clk_div_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_in_i,
    input  logic             div_load_i,
    input  logic             apply_i,
    output logic [WIDTH-1:0] div_cur_o,
    output logic             div_pending_o
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic             pending_q, pending_d;

    always_comb begin
        shadow_d  = shadow_q;
        cur_d     = cur_q;
        pending_d = pending_q;
        // Only a value that was already pending before this edge is applied;
        // a load on the boundary edge itself waits for the next boundary.
        if (apply_i && pending_q) begin
            cur_d     = shadow_q;
            pending_d = 1'b0;
        end
        if (div_load_i) begin
            shadow_d  = WIDTH'(clamp_div(32'(div_in_i)));
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            cur_q     <= WIDTH'(DEF_DIV);
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            cur_q     <= cur_d;
            pending_q <= pending_d;
        end
    end

    assign div_cur_o     = cur_q;
    assign div_pending_o = pending_q;

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with tick enable
// Optional feature: define CLKDIV_SYNC_EN to add the sync input (forced period restart).
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            count enable; phase frozen while low
//   sync          (CLKDIV_SYNC_EN only) with en, forces a period boundary
//   div_in        new divisor value
//   div_load      one-cycle strobe loading div_in into the shadow register
//   div_pending   a loaded divisor is waiting for the next boundary
//   div_cur       divisor currently in effect
//   clk_out       registered divided square wave, high ceil(D/2) cycles
//   tick          registered one-cycle pulse with each clk_out rising edge
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_pending,
    output logic [WIDTH-1:0] div_cur,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             boundary;
    logic             wrap;
    logic             sync_hit;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    assign wrap = (cnt_q == div_cur - WIDTH'(1));

    always_comb begin
        boundary  = 1'b0;
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (en) begin
            // sync takes priority; either way the new phase is 0.
            boundary  = sync_hit || wrap;
            cnt_d     = boundary ? '0 : cnt_q + WIDTH'(1);
            // At the boundary cnt_d is 0, which is below any half period, so the
            // divisor switching on that same edge never affects this compare.
            clk_out_d = (32'(cnt_d) < half_div(32'(div_cur)));
            tick_d    = boundary;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    clk_div_shadow #(
        .WIDTH   (WIDTH),
        .DEF_DIV (DEF_DIV)
    ) u_shadow (
        .clk           (clk),
        .rst           (rst),
        .div_in_i      (div_in),
        .div_load_i    (div_load),
        .apply_i       (boundary),
        .div_cur_o     (div_cur),
        .div_pending_o (div_pending)
    );

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule
